// File: rtl/edge_event_capture.sv
// rtl/edge_event_capture.sv - multi-channel synchronised edge detector with sticky status, irq and event counter
// Optional per-channel glitch filter compiled in with `define EDGE_FILTER_EN.
module edge_event_capture #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [DATA_WIDTH-1:0]   in,
    input  logic [2*DATA_WIDTH-1:0] mode,
    input  logic [DATA_WIDTH-1:0]   clr,
    input  logic [DATA_WIDTH-1:0]   irq_mask,
    input  logic                    cnt_clr,
    output logic [DATA_WIDTH-1:0]   pulse_out,
    output logic [DATA_WIDTH-1:0]   status,
    output logic                    irq,
    output logic [COUNT_WIDTH-1:0]  evt_count
);

    logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] r_prev;
    logic [DATA_WIDTH-1:0] w_s;
    logic [DATA_WIDTH-1:0] w_f;
    logic [DATA_WIDTH-1:0] w_rise;
    logic [DATA_WIDTH-1:0] w_fall;
    logic [DATA_WIDTH-1:0] w_sel;
    logic                  w_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

`ifdef EDGE_FILTER_EN
    localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT_CYCLES - 1);

    logic [FW-1:0]         r_cnt [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] r_filt;

    // A new level is accepted only after it has differed for FILT_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= '0;
            for (int ch = 0; ch < DATA_WIDTH; ch++) begin
                r_cnt[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < DATA_WIDTH; ch++) begin
                if (w_s[ch] == r_filt[ch]) begin
                    r_cnt[ch] <= '0;
                end else if (r_cnt[ch] == FILT_MAX) begin
                    r_filt[ch] <= w_s[ch];
                    r_cnt[ch]  <= '0;
                end else begin
                    r_cnt[ch] <= r_cnt[ch] + 1'b1;
                end
            end
        end
    end

    assign w_f = r_filt;
`else
    assign w_f = w_s;
`endif

    assign w_rise = w_f & ~r_prev;
    assign w_fall = ~w_f & r_prev;

    always_comb begin
        w_sel = '0;
        for (int ch = 0; ch < DATA_WIDTH; ch++) begin
            case (mode[2*ch +: 2])
                2'b01:   w_sel[ch] = w_rise[ch];
                2'b10:   w_sel[ch] = w_fall[ch];
                2'b11:   w_sel[ch] = w_rise[ch] | w_fall[ch];
                default: w_sel[ch] = 1'b0;
            endcase
        end
    end

    assign w_any = |pulse_out;

    // prev tracks regardless of en so re-enabling never replays an old transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= '0;
            pulse_out <= '0;
            status    <= '0;
            evt_count <= '0;
        end else begin
            r_prev    <= w_f;
            pulse_out <= en ? w_sel : '0;
            status    <= (status & ~clr) | pulse_out;
            if (cnt_clr) begin
                evt_count <= w_any ? COUNT_WIDTH'(1) : '0;
            end else if (w_any && (evt_count != {COUNT_WIDTH{1'b1}})) begin
                evt_count <= evt_count + 1'b1;
            end
        end
    end

    assign irq = |(status & irq_mask);

endmodule

// File: tb/tb_edge_event_capture.sv
// tb/tb_edge_event_capture.sv - randomized and directed bench for edge_event_capture against a behavioural model
`timescale 1ns/1ps
module tb_edge_event_capture;

    localparam int DW  = 8;
    localparam int S   = 2;
    localparam int FC  = 4;
    localparam int CW  = 4;
`ifdef EDGE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int LAT = S + 1 + (FILT ? FC : 0);
    localparam int P   = FILT ? FC + 2 : 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            en = 1'b0;
    logic            cnt_clr = 1'b0;
    logic [DW-1:0]   t_in = '0;
    logic [DW-1:0]   clr = '0;
    logic [DW-1:0]   irq_mask = '0;
    logic [2*DW-1:0] mode = '0;
    logic [DW-1:0]   pulse_out;
    logic [DW-1:0]   status;
    logic            irq;
    logic [CW-1:0]   evt_count;

    edge_event_capture #(
        .DATA_WIDTH(DW), .SYNC_STAGES(S), .FILT_CYCLES(FC), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in(t_in), .mode(mode), .clr(clr),
        .irq_mask(irq_mask), .cnt_clr(cnt_clr), .pulse_out(pulse_out),
        .status(status), .irq(irq), .evt_count(evt_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: per-cycle input history since the last reset; accepted level f derived from it.
    int              c;
    logic [DW-1:0]   h_in   [0:8191];
    logic [DW-1:0]   h_f    [0:8191];
    logic [DW-1:0]   h_clr  [0:8191];
    logic [2*DW-1:0] h_mode [0:8191];
    logic            h_en   [0:8191];
    logic            h_cc   [0:8191];
    int              m_run  [DW];
    logic [DW-1:0]   m_pulse;
    logic [DW-1:0]   m_status;
    logic [CW-1:0]   m_evt;

    function automatic logic [DW-1:0] f_at(input int k);
        return (k < 0) ? '0 : h_f[k];
    endfunction

    function automatic logic [DW-1:0] s_at(input int k);
        return (k < S) ? '0 : h_in[k-S];
    endfunction

    function automatic logic [DW-1:0] edges(input logic [DW-1:0] f, input logic [DW-1:0] p,
                                            input logic [2*DW-1:0] md);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++) begin
            case (md[2*i +: 2])
                2'd1:    r[i] = f[i] && !p[i];
                2'd2:    r[i] = !f[i] && p[i];
                2'd3:    r[i] = f[i] != p[i];
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic string obs();
        return $sformatf("got p=%h s=%h irq=%b cnt=%h, expected p=%h s=%h irq=%b cnt=%h",
                         pulse_out, status, irq, evt_count,
                         m_pulse, m_status, |(m_status & irq_mask), m_evt);
    endfunction

    task automatic model_reset();
        c        = 0;
        h_f[0]   = '0;
        m_pulse  = '0;
        m_status = '0;
        m_evt    = '0;
        for (int i = 0; i < DW; i++) m_run[i] = 0;
    endtask

    task automatic model_edge();
        int            k;
        logic [DW-1:0] np, ns, sp, nf;
        logic [CW-1:0] ne;
        k  = c;
        np = h_en[k-1] ? edges(f_at(k-1), f_at(k-2), h_mode[k-1]) : '0;
        ns = (m_status & ~h_clr[k-1]) | m_pulse;
        if (h_cc[k-1])                   ne = (m_pulse != 0) ? CW'(1) : '0;
        else if (m_pulse != 0 && m_evt != {CW{1'b1}}) ne = m_evt + 1'b1;
        else                             ne = m_evt;
        if (FILT) begin
            sp = s_at(k-1);
            nf = h_f[k-1];
            for (int i = 0; i < DW; i++) begin
                if (sp[i] != h_f[k-1][i]) begin
                    m_run[i]++;
                    if (m_run[i] == FC) begin
                        nf[i]    = sp[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            h_f[k] = nf;
        end else begin
            h_f[k] = s_at(k);
        end
        m_pulse  = np;
        m_status = ns;
        m_evt    = ne;
    endtask

    task automatic step(input logic [DW-1:0] vin, input logic ven, input logic [2*DW-1:0] vmode,
                        input logic [DW-1:0] vclr, input logic vcc);
        t_in = vin; en = ven; mode = vmode; clr = vclr; cnt_clr = vcc;
        h_in[c] = vin; h_en[c] = ven; h_mode[c] = vmode; h_clr[c] = vclr; h_cc[c] = vcc;
        @(posedge clk);
        #1;
        c++;
        model_edge();
    endtask

    task automatic do_reset(input logic [DW-1:0] vin);
        rst_n = 1'b0; t_in = vin; en = 1'b0; clr = '0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0; t_in = 8'h80; irq_mask = 8'hFF;
        #1;
        n_checks++;
        if ({pulse_out, status, irq, evt_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got p=%h s=%h irq=%b cnt=%h, expected all zero",
                     pulse_out, status, irq, evt_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int j = 0; j < LAT + 3; j++) begin
            step(8'h80, 1'b1, 16'h5555, '0, 1'b0);
            n_checks++;
            if ({pulse_out, status, irq, evt_count} !== {m_pulse, m_status, |(m_status & irq_mask), m_evt}) begin
                n_errors++;
                $display("FAIL held_high_release cyc=%0d %s", c, obs());
            end
            if (c == LAT) begin
                n_checks++;
                if (pulse_out !== 8'h80) begin
                    n_errors++;
                    $display("FAIL held_high_pulse: got %h, expected 80", pulse_out);
                end
            end
        end
    endtask

    task automatic test_single_rise();
        do_reset('0);
        irq_mask = 8'h00;
        for (int j = 0; j < LAT + 4; j++) begin
            step(8'h01, 1'b1, 16'h5555, '0, 1'b0);
            n_checks++;
            if (pulse_out !== ((c == LAT) ? 8'h01 : 8'h00)) begin
                n_errors++;
                $display("FAIL single_rise_pulse cyc=%0d: got %h, expected %h", c, pulse_out,
                         (c == LAT) ? 8'h01 : 8'h00);
            end
            n_checks++;
            if ({status, evt_count} !== {m_status, m_evt}) begin
                n_errors++;
                $display("FAIL single_rise_model cyc=%0d %s", c, obs());
            end
        end
        n_checks++;
        if (status !== 8'h01 || evt_count !== 4'd1) begin
            n_errors++;
            $display("FAIL single_rise_final: got s=%h cnt=%h, expected s=01 cnt=1", status, evt_count);
        end
    endtask

    task automatic test_dual();
        int            hits;
        logic [CW-1:0] base;
        for (int j = 0; j < LAT + 2; j++) begin
            step(8'h06, 1'b1, 16'h0038, '0, 1'b0);
            n_checks++;
            if ({pulse_out, status, evt_count} !== {m_pulse, m_status, m_evt}) begin
                n_errors++;
                $display("FAIL dual_setup cyc=%0d %s", c, obs());
            end
        end
        base = m_evt;
        hits = 0;
        for (int j = 0; j < LAT + 2; j++) begin
            step(8'h00, 1'b1, 16'h0038, '0, 1'b0);
            if (pulse_out == 8'h06) hits++;
            n_checks++;
            if ({pulse_out, status, evt_count} !== {m_pulse, m_status, m_evt}) begin
                n_errors++;
                $display("FAIL dual_fall cyc=%0d %s", c, obs());
            end
        end
        n_checks++;
        if (hits != 1 || evt_count !== base + 1'b1) begin
            n_errors++;
            $display("FAIL dual_count: got hits=%0d cnt=%h, expected hits=1 cnt=%h", hits, evt_count, base + 1'b1);
        end
    endtask

    task automatic test_glitch();
        int hits_short, hits_wide;
        hits_short = 0;
        hits_wide  = 0;
        for (int j = 0; j < 15 + 20; j++) begin
            logic [DW-1:0] v;
            v = ((j < 3) || (j >= 15 && j < 21)) ? 8'h08 : 8'h00;
            step(v, 1'b1, 16'hFFFF, '0, 1'b0);
            if (pulse_out[3]) begin
                if (j < 15) hits_short++;
                else        hits_wide++;
            end
            n_checks++;
            if ({pulse_out, status, evt_count} !== {m_pulse, m_status, m_evt}) begin
                n_errors++;
                $display("FAIL glitch_model cyc=%0d %s", c, obs());
            end
        end
        n_checks++;
        if (hits_short != (FILT ? 0 : 2) || hits_wide != 2) begin
            n_errors++;
            $display("FAIL glitch_counts: got short=%0d wide=%0d, expected short=%0d wide=2",
                     hits_short, hits_wide, FILT ? 0 : 2);
        end
    endtask

    task automatic test_clr_coincide();
        int guard;
        do_reset('0);
        irq_mask = 8'h01;
        for (int j = 0; j < LAT + 2; j++) step(8'h01, 1'b1, 16'h5555, '0, 1'b0);
        for (int j = 0; j < P + LAT + 1; j++) step(8'h00, 1'b1, 16'h5555, '0, 1'b0);
        guard = 0;
        do begin
            step(8'h01, 1'b1, 16'h5555, '0, 1'b0);
            guard++;
        end while (!m_pulse[0] && guard < 30);
        n_checks++;
        if (guard >= 30 || pulse_out !== 8'h01) begin
            n_errors++;
            $display("FAIL clr_wait_pulse: got p=%h after %0d cycles, expected 01", pulse_out, guard);
        end
        step(8'h01, 1'b1, 16'h5555, 8'h01, 1'b0);
        n_checks++;
        if (status[0] !== 1'b1 || irq !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_set_wins: got s0=%b irq=%b, expected 1 1", status[0], irq);
        end
        step(8'h01, 1'b1, 16'h5555, 8'h01, 1'b0);
        n_checks++;
        if (status !== 8'h00 || irq !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_clears: got s=%h irq=%b, expected 00 0", status, irq);
        end
    endtask

    task automatic test_saturate();
        int            hits;
        logic [DW-1:0] v;
        v = 8'h01;
        step(v, 1'b1, 16'hFFFF, '0, 1'b1);
        n_checks++;
        if (evt_count !== 4'h0) begin
            n_errors++;
            $display("FAIL sat_initial_clear: got %h, expected 0", evt_count);
        end
        hits = 0;
        for (int t = 0; t < 17; t++) begin
            v = ~v & 8'h01;
            for (int j = 0; j < P; j++) begin
                step(v, 1'b1, 16'hFFFF, '0, 1'b0);
                if (pulse_out[0]) hits++;
                n_checks++;
                if ({pulse_out, evt_count} !== {m_pulse, m_evt}) begin
                    n_errors++;
                    $display("FAIL sat_model cyc=%0d %s", c, obs());
                end
            end
        end
        for (int j = 0; j < LAT + 2; j++) begin
            step(v, 1'b1, 16'hFFFF, '0, 1'b0);
            if (pulse_out[0]) hits++;
        end
        n_checks++;
        if (hits != 17 || evt_count !== 4'hF) begin
            n_errors++;
            $display("FAIL sat_value: got hits=%0d cnt=%h, expected hits=17 cnt=f", hits, evt_count);
        end
        step(v, 1'b1, 16'hFFFF, '0, 1'b1);
        n_checks++;
        if (evt_count !== 4'h0) begin
            n_errors++;
            $display("FAIL sat_cnt_clr: got %h, expected 0", evt_count);
        end
    endtask

    task automatic test_enable();
        int            hits, guard;
        logic [DW-1:0] v;
        logic [CW-1:0] base;
        v = t_in;
        irq_mask = 8'hFF;
        step(v, 1'b1, 16'hFFFF, 8'hFF, 1'b0);
        step(v, 1'b1, 16'hFFFF, 8'h00, 1'b0);
        base = m_evt;
        hits = 0;
        for (int t = 0; t < 4; t++) begin
            v = v ^ 8'h20;
            for (int j = 0; j < P + 1; j++) begin
                step(v, 1'b0, 16'hFFFF, '0, 1'b0);
                if (pulse_out != 0) hits++;
            end
        end
        for (int j = 0; j < LAT + 2; j++) begin
            step(v, 1'b0, 16'hFFFF, '0, 1'b0);
            if (pulse_out != 0) hits++;
        end
        for (int j = 0; j < 10; j++) begin
            step(v, 1'b1, 16'hFFFF, '0, 1'b0);
            if (pulse_out != 0) hits++;
        end
        n_checks++;
        if (hits != 0 || status !== 8'h00 || evt_count !== base) begin
            n_errors++;
            $display("FAIL enable_gating: got hits=%0d s=%h cnt=%h, expected hits=0 s=00 cnt=%h",
                     hits, status, evt_count, base);
        end
        v = v ^ 8'h20;
        guard = 0;
        do begin
            step(v, 1'b1, 16'hFFFF, '0, 1'b0);
            guard++;
        end while (!m_status[5] && guard < 30);
        n_checks++;
        if (guard >= 30 || status !== 8'h20 || irq !== 1'b1) begin
            n_errors++;
            $display("FAIL enable_resume: got s=%h irq=%b, expected 20 1", status, irq);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pulse_out, status, irq, evt_count} !== '0) begin
            n_errors++;
            $display("FAIL async_reset: got p=%h s=%h irq=%b cnt=%h, expected all zero",
                     pulse_out, status, irq, evt_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        hits = 0;
        for (int j = 0; j < LAT + 3; j++) begin
            step(8'h00, 1'b1, 16'hFFFF, '0, 1'b0);
            if (pulse_out != 0) hits++;
        end
        n_checks++;
        if (hits != 0 || m_pulse !== 8'h00) begin
            n_errors++;
            $display("FAIL post_reset_quiet: got hits=%0d, expected 0", hits);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0]   v, cl;
        logic [2*DW-1:0] md;
        logic            ve, vc;
        v  = t_in;
        md = 16'hFFFF;
        for (int j = 0; j < 600; j++) begin
            if (FILT) v = ($urandom_range(0, 5) == 0) ? (v ^ DW'($urandom)) : v;
            else      v = v ^ (DW'($urandom) & DW'($urandom));
            if ($urandom_range(0, 15) == 0) md = 16'($urandom);
            ve = ($urandom_range(0, 7) != 0);
            cl = DW'($urandom) & DW'($urandom) & DW'($urandom);
            vc = ($urandom_range(0, 31) == 0);
            irq_mask = DW'($urandom);
            step(v, ve, md, cl, vc);
            n_checks++;
            if ({pulse_out, status, irq, evt_count} !== {m_pulse, m_status, |(m_status & irq_mask), m_evt}) begin
                n_errors++;
                $display("FAIL random cyc=%0d %s", c, obs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_dual();
        test_glitch();
        test_clr_coincide();
        test_saturate();
        test_enable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish before 2ms");
        $fatal(1);
    end

endmodule
